// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle between the sync generator (master) and the pixel/colour stage (slave).
interface vga_sync_gen_if;
    logic       ena;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       display_on;
    logic       hsync;
    logic       vsync;
    logic       pix_tick;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_cnt;

    modport master (
        input  ena,
        output hpos, vpos, display_on, hsync, vsync,
        output pix_tick, line_start, frame_start, frame_cnt
    );

    modport slave (
        output ena,
        input  hpos, vpos, display_on, hsync, vsync,
        input  pix_tick, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel divider, h/v counters, syncs, strobes and frame counter.
// Optional frame counter register is built only when VGA_SYNC_FRAME_CNT_EN is defined.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0,
    parameter int CLK_DIV   = 1
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_gen_if.master bus
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    generate
        if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_total
            $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_sync_gen: CLK_DIV must be at least 1");
        end
    endgenerate

    logic [DIV_W-1:0] div_q;
    logic [9:0]       hpos_q;
    logic [9:0]       vpos_q;
    logic             display_on_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             line_start_q;
    logic             frame_start_q;

    logic       tick;
    logic       h_last;
    logic       v_last;
    logic [9:0] hpos_nxt;
    logic [9:0] vpos_nxt;

    always_comb begin
        tick     = bus.ena && (div_q == DIV_W'(CLK_DIV - 1));
        h_last   = (hpos_q == 10'(H_TOTAL - 1));
        v_last   = (vpos_q == 10'(V_TOTAL - 1));
        hpos_nxt = h_last ? 10'd0 : hpos_q + 10'd1;
        vpos_nxt = vpos_q;
        if (h_last) begin
            vpos_nxt = v_last ? 10'd0 : vpos_q + 10'd1;
        end
    end

    // Registered outputs are derived from the next counter values so they line up with hpos/vpos.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            hpos_q        <= '0;
            vpos_q        <= '0;
            display_on_q  <= 1'b1;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            if (bus.ena) begin
                div_q <= tick ? '0 : div_q + 1'b1;
            end
            line_start_q  <= tick && h_last;
            frame_start_q <= tick && h_last && v_last;
            if (tick) begin
                hpos_q       <= hpos_nxt;
                vpos_q       <= vpos_nxt;
                display_on_q <= (hpos_nxt < 10'(H_VISIBLE)) && (vpos_nxt < 10'(V_VISIBLE));
                hsync_q      <= ((hpos_nxt >= 10'(HS_START)) && (hpos_nxt < 10'(HS_END)))
                                ? SYNC_POL : ~SYNC_POL;
                vsync_q      <= ((vpos_nxt >= 10'(VS_START)) && (vpos_nxt < 10'(VS_END)))
                                ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (tick && h_last && v_last) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
`else
    assign bus.frame_cnt = 8'd0;
`endif

    assign bus.hpos        = hpos_q;
    assign bus.vpos        = vpos_q;
    assign bus.display_on  = display_on_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.pix_tick    = tick;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
endmodule
